// File: rtl/dffre_write_arbiter.sv
// rtl/dffre_write_arbiter.sv - round-robin write arbiter for a shared enable-gated register
// Optional owner lock is compiled in with DFFRE_ARB_LOCK_EN.
module dffre_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    i_Reset,
  input  logic [NREQ-1:0]         i_Req,
  input  logic [NREQ*WIDTH-1:0]   i_Data,
  input  logic [NREQ-1:0]         i_Lock,
  output logic [NREQ-1:0]         o_Grant,
  output logic                    o_Enable,
  output logic [WIDTH-1:0]        o_Q,
  output logic [$clog2(NREQ)-1:0] o_Owner,
  output logic                    o_Locked
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] eff;
  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;

  // The requester granted this cycle is masked so one port cannot take back-to-back writes.
  always_comb begin
    eff   = i_Req & ~o_Grant;
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef DFFRE_ARB_LOCK_EN
  logic lock_hold;
  assign lock_hold = (state != IDLE) && i_Lock[o_Owner];
`else
  logic unused_lock;
  assign unused_lock = ^i_Lock;
`endif

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      o_Grant  <= '0;
      o_Enable <= 1'b0;
      o_Q      <= '0;
      o_Owner  <= '0;
      o_Locked <= 1'b0;
      ptr      <= IW'(NREQ - 1);
      state    <= IDLE;
    end else begin
`ifdef DFFRE_ARB_LOCK_EN
      if (lock_hold) begin
        // Owner keeps exclusive, unmasked access for as long as it holds its lock.
        state    <= LOCKED;
        o_Locked <= 1'b1;
        ptr      <= o_Owner;
        if (i_Req[o_Owner]) begin
          o_Q      <= i_Data[o_Owner*WIDTH +: WIDTH];
          o_Grant  <= ONE << o_Owner;
          o_Enable <= 1'b1;
        end else begin
          o_Grant  <= '0;
          o_Enable <= 1'b0;
        end
      end else
`endif
      if (found) begin
        o_Q      <= i_Data[win*WIDTH +: WIDTH];
        o_Grant  <= ONE << win;
        o_Enable <= 1'b1;
        o_Owner  <= win;
        ptr      <= win;
        o_Locked <= 1'b0;
        state    <= GRANT;
      end else begin
        o_Grant  <= '0;
        o_Enable <= 1'b0;
        o_Locked <= 1'b0;
        state    <= IDLE;
      end
    end
  end

endmodule
